gcd_arbiter: RTL and testbench

Shares a single gcd datapath unit among N_REQ requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The arbiter sequences the gcd unit's start/done protocol and returns the result to the granted requester as a one-cycle response pulse. It also handles two cases without the datapath: zero operands are bypassed, and a hung gcd unit is caught by a watchdog timeout.

---
 rtl/gcd_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// gcd_arbiter
// Shares one gcd datapath unit among N_REQ requesters with round-robin
// arbitration. A granted operand pair is either answered directly (when an
// operand is zero, the result is a|b) or sent to the gcd unit. The arbiter
// then waits for gcd_done, or gives up after TIMEOUT cycles and reports an
// error. Only one operation is in flight at any time.
//
// Ports:
//   clk, reset_n            rising-edge clock, synchronous active-low reset
//   req_valid/req_a/req_b   per-requester request, operands packed WIDTH each
//   req_ready               one-hot pulse, request accepted
//   resp_valid              one-hot pulse, response for that requester
//   resp_result/err/id      response payload (err=1 means timeout, result 0)
//   busy                    arbiter not idle
//   gcd_a/gcd_b/gcd_start   operands and start pulse to the gcd unit
//   gcd_result/gcd_done     completion from the gcd unit
module gcd_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_err,
  output logic [ID_W-1:0]        resp_id,
  output logic                   busy,
  output logic [WIDTH-1:0]       gcd_a,
  output logic [WIDTH-1:0]       gcd_b,
  output logic                   gcd_start,
  input  logic [WIDTH-1:0]       gcd_result,
  input  logic                   gcd_done
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state, state_n;
  logic [ID_W-1:0]   ptr, ptr_n;
  logic [ID_W-1:0]   grant, grant_n;
  logic [CNT_W-1:0]  wait_cnt, cnt_n;
  logic [WIDTH-1:0]  a_n, b_n, result_n;
  logic [N_REQ-1:0]  ready_n, rvalid_n;
  logic              start_n, err_n;
  logic [ID_W-1:0]   id_n;

  logic [WIDTH-1:0]  a_arr [N_REQ];
  logic [WIDTH-1:0]  b_arr [N_REQ];
  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W:0]     cand;

  // Unpack the flat operand buses so the grantee can be indexed directly.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search starting at ptr. The candidate index carries one
  // extra bit so the modulo wrap also works when N_REQ is not a power of 2.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values produced here appear during the state being entered.
  // gcd_a/gcd_b double as the latched operands and stay put until the next
  // grant, which keeps them stable throughout WAIT.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    grant_n  = grant;
    cnt_n    = wait_cnt;
    a_n      = gcd_a;
    b_n      = gcd_b;
    start_n  = 1'b0;
    ready_n  = '0;
    rvalid_n = '0;
    result_n = resp_result;
    err_n    = resp_err;
    id_n     = resp_id;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n       = pick;
          a_n           = a_arr[pick];
          b_n           = b_arr[pick];
          ready_n[pick] = 1'b1;
          start_n       = (a_arr[pick] != '0) && (b_arr[pick] != '0);
          state_n       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A zero operand makes the answer a|b, so the datapath is skipped.
        if ((gcd_a == '0) || (gcd_b == '0)) begin
          rvalid_n[grant] = 1'b1;
          id_n            = grant;
          result_n        = gcd_a | gcd_b;
          err_n           = 1'b0;
          state_n         = S_RESP;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done is checked before the timeout so a coincident done still wins.
        if (gcd_done) begin
          rvalid_n[grant] = 1'b1;
          id_n            = grant;
          result_n        = gcd_result;
          err_n           = 1'b0;
          state_n         = S_RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT-1)) begin
          rvalid_n[grant] = 1'b1;
          id_n            = grant;
          result_n        = '0;
          err_n           = 1'b1;
          state_n         = S_RESP;
        end else begin
          cnt_n = wait_cnt + 1'b1;
        end
      end
      S_RESP: begin
        ptr_n   = (grant == ID_W'(N_REQ-1)) ? '0 : grant + 1'b1;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers. Reset discards any in-flight operation
  // without answering it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      grant       <= '0;
      wait_cnt    <= '0;
      gcd_a       <= '0;
      gcd_b       <= '0;
      gcd_start   <= 1'b0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
      resp_id     <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      wait_cnt    <= cnt_n;
      gcd_a       <= a_n;
      gcd_b       <= b_n;
      gcd_start   <= start_n;
      req_ready   <= ready_n;
      resp_valid  <= rvalid_n;
      resp_result <= result_n;
      resp_err    <= err_n;
      resp_id     <= id_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter
// Randomised and directed bench for gcd_arbiter with a behavioural gcd unit
// stub. Pending requests live in one queue; a transaction-level model picks
// the round-robin winner and predicts when req_ready, gcd_start and
// resp_valid appear and what the response carries.
module tb_gcd_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk        = 1'b0;
  logic           reset_n    = 1'b0;
  logic [N-1:0]   req_valid  = '0;
  logic [N*W-1:0] req_a      = '0;
  logic [N*W-1:0] req_b      = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_result;
  logic           resp_err;
  logic [1:0]     resp_id;
  logic           busy;
  logic [W-1:0]   gcd_a;
  logic [W-1:0]   gcd_b;
  logic           gcd_start;
  logic [W-1:0]   gcd_result = '0;
  logic           gcd_done   = 1'b0;

  gcd_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_result(resp_result), .resp_err(resp_err), .resp_id(resp_id),
    .busy(busy), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
    .gcd_result(gcd_result), .gcd_done(gcd_done)
  );

  always #5 clk = ~clk;

  // lat: cycles from gcd_start to gcd_done in the stub; 0 means never.
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
  } req_t;

  req_t        pend[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, idle_at = 0, model_ptr = 0;
  int          exp_ready_cyc = -1, exp_resp_cyc = -1, exp_id = 0;
  int          stub_lat = 0, done_cyc = -1, rst_cycles = 0;
  logic        exp_start = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_a = '0, exp_b = '0, exp_result = '0, stub_res = '0;

  function automatic logic [31:0] gcdRef(logic [31:0] a, logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [N-1:0] oneHot(int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Oldest pending request of requester id, or -1.
  function automatic int headIdx(int id);
    for (int k = 0; k < pend.size(); k++) begin
      if (pend[k].id == id) return k;
    end
    return -1;
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus(int id, logic [31:0] a, logic [31:0] b, int lat);
    req_t r;
    r.id = id; r.a = a; r.b = b; r.lat = lat;
    pend.push_back(r);
  endtask

  task automatic applyReset(int n);
    rst_cycles = n;
  endtask

  // One clock: check the outputs of the new cycle, run the gcd stub, then
  // drive inputs and let the model make the grant decision for this cycle.
  task automatic stepCycle();
    logic         rs;
    logic [N-1:0] exp_rr, exp_rv;
    int           h, pick, c;
    req_t         r;
    rs = reset_n;
    @(posedge clk);
    #1;
    cyc++;
    if (!rs) begin
      checkOutput("rst_req_ready",  32'(req_ready),  32'h0);
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
      checkOutput("rst_resp_result", resp_result,    32'h0);
      checkOutput("rst_resp_err",   32'(resp_err),   32'h0);
      checkOutput("rst_resp_id",    32'(resp_id),    32'h0);
      checkOutput("rst_gcd_start",  32'(gcd_start),  32'h0);
      checkOutput("rst_gcd_a",      gcd_a,           32'h0);
      checkOutput("rst_gcd_b",      gcd_b,           32'h0);
      checkOutput("rst_busy",       32'(busy),       32'h0);
    end else begin
      exp_rr = (cyc == exp_ready_cyc) ? oneHot(exp_id) : '0;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_rr));
      checkOutput("gcd_start", 32'(gcd_start), 32'(cyc == exp_ready_cyc && exp_start));
      if (cyc == exp_ready_cyc && exp_start) begin
        checkOutput("gcd_a", gcd_a, exp_a);
        checkOutput("gcd_b", gcd_b, exp_b);
      end
      exp_rv = (cyc == exp_resp_cyc) ? oneHot(exp_id) : '0;
      checkOutput("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (cyc == exp_resp_cyc) begin
        checkOutput("resp_result", resp_result, exp_result);
        checkOutput("resp_err", 32'(resp_err), 32'(exp_err));
        checkOutput("resp_id", 32'(resp_id), 32'(exp_id));
      end
      checkOutput("busy", 32'(busy), 32'(cyc < idle_at));
      if (gcd_start) begin
        done_cyc = (stub_lat > 0) ? cyc + stub_lat : -1;
        stub_res = gcdRef(gcd_a, gcd_b);
      end
      if (cyc == exp_resp_cyc) begin
        h = headIdx(exp_id);
        if (h >= 0) pend.delete(h);
        done_cyc = -1;
      end
    end

    if (rst_cycles > 0) begin
      rst_cycles--;
      reset_n       = 1'b0;
      exp_ready_cyc = -1;
      exp_resp_cyc  = -1;
      done_cyc      = -1;
      model_ptr     = 0;
      idle_at       = cyc + 1;
    end else begin
      reset_n = 1'b1;
    end
    gcd_done   = (cyc == done_cyc);
    gcd_result = gcd_done ? stub_res : $urandom();
    for (int i = 0; i < N; i++) begin
      h = headIdx(i);
      req_valid[i] = (h >= 0);
      req_a[i*W +: W] = (h >= 0) ? pend[h].a : $urandom();
      req_b[i*W +: W] = (h >= 0) ? pend[h].b : $urandom();
    end

    if (reset_n && cyc >= idle_at && req_valid != '0) begin
      pick = -1;
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (pick < 0 && headIdx(c) >= 0) pick = c;
      end
      r             = pend[headIdx(pick)];
      exp_id        = pick;
      exp_a         = r.a;
      exp_b         = r.b;
      exp_ready_cyc = cyc + 1;
      exp_start     = (r.a != 0) && (r.b != 0);
      stub_lat      = r.lat;
      if (!exp_start) begin
        exp_resp_cyc = cyc + 2;
        exp_result   = r.a | r.b;
        exp_err      = 1'b0;
      end else if (r.lat >= 1 && r.lat <= TO) begin
        exp_resp_cyc = cyc + 2 + r.lat;
        exp_result   = gcdRef(r.a, r.b);
        exp_err      = 1'b0;
      end else begin
        exp_resp_cyc = cyc + 2 + TO;
        exp_result   = '0;
        exp_err      = 1'b1;
      end
      idle_at   = exp_resp_cyc + 1;
      model_ptr = (pick + 1) % N;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pend.size() != 0 || cyc < idle_at) && n < 4000) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_pending", 32'(pend.size()), 32'h0);
  endtask

  initial begin
    logic [31:0] f, a, b;
    int          z, lat;

    applyReset(2);
    repeat (4) stepCycle();

    $display("[TB] single request");
    applyStimulus(0, 48, 18, 10);
    drain();

    $display("[TB] contention");
    applyReset(1);
    stepCycle();
    applyStimulus(0, 12, 8, 3);
    applyStimulus(1, 35, 14, 5);
    applyStimulus(2, 81, 27, 1);
    applyStimulus(3, 17, 5, 7);
    drain();

    $display("[TB] fairness and wrap");
    applyStimulus(2, 40, 30, 4);
    drain();
    applyStimulus(0, 64, 48, 2);
    applyStimulus(3, 21, 14, 2);
    drain();

    $display("[TB] zero bypass");
    applyStimulus(1, 0, 35, 5);
    applyStimulus(2, 0, 0, 5);
    applyStimulus(3, 9, 0, 5);
    drain();

    $display("[TB] timeout");
    applyStimulus(0, 30, 12, 0);
    drain();
    applyStimulus(1, 30, 12, 6);
    applyStimulus(2, 99, 33, TO);
    applyStimulus(3, 99, 33, TO + 1);
    drain();

    $display("[TB] reset in wait");
    applyStimulus(1, 100, 75, 12);
    repeat (5) stepCycle();
    applyReset(1);
    stepCycle();
    drain();

    $display("[TB] random traffic");
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 3) == 0 && pend.size() < 8) begin
        f = $urandom_range(1, 40);
        a = f * $urandom_range(1, 250);
        b = f * $urandom_range(1, 250);
        z = $urandom_range(0, 11);
        if (z == 0) a = 0;
        if (z == 1) b = 0;
        z = $urandom_range(0, 19);
        lat = (z == 0) ? 0 : (z == 1) ? TO : $urandom_range(1, TO + 2);
        applyStimulus($urandom_range(0, N - 1), a, b, lat);
      end
      stepCycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
